// File: rtl/xdma_from_remote_demux.sv
// Inbound AXI4 write-only subordinate for this cluster's MMIO window. Each burst
// is decoded by address into the cfg, data or grant stream; W beats pass through
// combinationally, and one B response is returned per burst.
module xdma_from_remote_demux #(
  parameter int unsigned          AddrWidth           = 48,
  parameter int unsigned          DataWidth           = 512,
  parameter int unsigned          IdWidth             = 8,
  parameter logic [AddrWidth-1:0] ClusterAddressSpace = 48'h10_0000,
  parameter logic [AddrWidth-1:0] MMIOSize            = 48'h1000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [AddrWidth-1:0]         cluster_base_addr_i,
  input  logic                         aw_valid_i,
  output logic                         aw_ready_o,
  input  logic [IdWidth-1:0]           aw_id_i,
  input  logic [AddrWidth-1:0]         aw_addr_i,
  input  logic [7:0]                   aw_len_i,
  input  logic [2:0]                   aw_size_i,
  input  logic [1:0]                   aw_burst_i,
  input  logic                         w_valid_i,
  output logic                         w_ready_o,
  input  logic [DataWidth-1:0]         w_data_i,
  input  logic [DataWidth/8-1:0]       w_strb_i,
  input  logic                         w_last_i,
  output logic                         b_valid_o,
  input  logic                         b_ready_i,
  output logic [IdWidth-1:0]           b_id_o,
  output logic [1:0]                   b_resp_o,
  output logic [DataWidth-1:0]         cfg_o,
  output logic                         cfg_valid_o,
  input  logic                         cfg_ready_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [DataWidth/8-1:0]       data_strb_o,
  output logic                         data_last_o,
  output logic                         data_valid_o,
  input  logic                         data_ready_i,
  output logic [IdWidth+AddrWidth-1:0] grant_o,
  output logic                         grant_valid_o,
  input  logic                         grant_ready_i,
  // Debug view of the FSM: 0 IDLE, 1 FWD, 2 DROP, 3 RESP.
  output logic [1:0]                   state_o
);

  // Every channel uses AXI valid/ready: a transfer happens on a rising clk edge
  // where both are high; a raised valid and its payload hold until that transfer.

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2, RESP = 2'd3} state_e;
  typedef enum logic [1:0] {TGT_DATA = 2'd0, TGT_CFG = 2'd1, TGT_GRANT = 2'd2} tgt_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [AddrWidth-1:0] GrantLo = ClusterAddressSpace - MMIOSize;
  localparam logic [AddrWidth-1:0] CfgLo   = GrantLo - MMIOSize;
  localparam logic [AddrWidth-1:0] DataLo  = CfgLo - MMIOSize;

  state_e               state_q, state_d;
  tgt_e                 tgt_q, tgt_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [7:0]           len_q, len_d;
  logic [1:0]           resp_q, resp_d;
  logic [8:0]           beat_cnt_q, beat_cnt_d;

  // Address decode of the incoming AW.
  logic [AddrWidth-1:0] off;
  logic [8:0]           len_p1;
  logic [AddrWidth:0]   data_end;
  logic                 dec_miss, dec_err;
  tgt_e                 dec_tgt;

  always_comb begin
    off      = aw_addr_i - cluster_base_addr_i;
    len_p1   = {1'b0, aw_len_i} + 9'd1;
    data_end = {1'b0, off} + {{(AddrWidth-14){1'b0}}, len_p1, 6'b0};
    dec_miss = (aw_addr_i < cluster_base_addr_i) || (off >= ClusterAddressSpace);
    dec_tgt  = TGT_DATA;
    dec_err  = dec_miss || (aw_size_i != 3'd6) || (aw_burst_i != 2'b01);
    if (off >= GrantLo) begin
      dec_tgt = TGT_GRANT;
      if (aw_len_i != 8'd0) dec_err = 1'b1;
    end else if (off >= CfgLo) begin
      dec_tgt = TGT_CFG;
      if (aw_len_i != 8'd0) dec_err = 1'b1;
    end else if (off >= DataLo) begin
      dec_tgt = TGT_DATA;
      if (data_end > {1'b0, CfgLo}) dec_err = 1'b1;
    end else begin
      // Inside the cluster but below the MMIO windows: no stream to route to.
      dec_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tgt_q      <= TGT_DATA;
      id_q       <= '0;
      len_q      <= '0;
      resp_q     <= RespOkay;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      id_q       <= id_d;
      len_q      <= len_d;
      resp_q     <= resp_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    id_d          = id_q;
    len_d         = len_q;
    resp_d        = resp_q;
    beat_cnt_d    = beat_cnt_q;
    aw_ready_o    = 1'b0;
    w_ready_o     = 1'b0;
    b_valid_o     = 1'b0;
    cfg_valid_o   = 1'b0;
    data_valid_o  = 1'b0;
    grant_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          id_d       = aw_id_i;
          len_d      = aw_len_i;
          tgt_d      = dec_tgt;
          beat_cnt_d = '0;
          resp_d     = dec_err ? RespSlvErr : RespOkay;
          state_d    = dec_err ? DROP : FWD;
        end
      end
      FWD: begin
        unique case (tgt_q)
          TGT_CFG: begin
            cfg_valid_o = w_valid_i;
            w_ready_o   = cfg_ready_i;
          end
          TGT_GRANT: begin
            grant_valid_o = w_valid_i;
            w_ready_o     = grant_ready_i;
          end
          default: begin
            data_valid_o = w_valid_i;
            w_ready_o    = data_ready_i;
          end
        endcase
        if (w_valid_i && w_ready_o) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (w_last_i) begin
            state_d = RESP;
            if (beat_cnt_q + 9'd1 != {1'b0, len_q} + 9'd1) resp_d = RespSlvErr;
          end
        end
      end
      DROP: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) state_d = RESP;
      end
      RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // While reset is held no handshake may be offered on any channel.
    if (rst_i) begin
      aw_ready_o    = 1'b0;
      w_ready_o     = 1'b0;
      b_valid_o     = 1'b0;
      cfg_valid_o   = 1'b0;
      data_valid_o  = 1'b0;
      grant_valid_o = 1'b0;
    end
  end

  assign b_id_o      = id_q;
  assign b_resp_o    = resp_q;
  assign cfg_o       = w_data_i;
  assign data_o      = w_data_i;
  assign data_strb_o = w_strb_i;
  assign data_last_o = w_last_i;
  assign grant_o     = w_data_i[DataWidth-1 -: IdWidth+AddrWidth];
  assign state_o     = state_q;

endmodule
